// File: rtl/irq_controller.sv
// Multi-source interrupt controller: per-source synchroniser with edge/level pending,
// fixed-priority arbitration (index 0 highest) and a req/ack/done handshake with the core.

module irq_lane #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE        = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic clr,
    output logic pending
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   latched;
    logic                   synced;

    assign synced = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= '0;
            prev    <= 1'b0;
            latched <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], src};
            prev <= synced;
            // a fresh edge beats an ack clear landing in the same cycle
            if (synced && !prev) latched <= 1'b1;
            else if (clr)        latched <= 1'b0;
        end
    end

    assign pending = EDGE ? latched : synced;
endmodule

module irq_controller #(
    parameter int                 NUM_SRC     = 8,
    parameter int                 ID_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    parameter logic [NUM_SRC-1:0] EDGE_MASK   = {NUM_SRC{1'b1}},
    parameter int                 SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic [NUM_SRC-1:0] irq_en_i,
    input  logic               glb_en_i,
    input  logic               irq_ack_i,
    input  logic               irq_done_i,
    output logic               irq_req_o,
    output logic [ID_W-1:0]    irq_id_o,
    output logic [NUM_SRC-1:0] pending_o,
    output logic               busy_o
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             state, state_nxt;
    logic [ID_W-1:0]    id, id_nxt, win;
    logic [NUM_SRC-1:0] cand, clr;
    logic               any;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
        irq_lane #(
            .SYNC_STAGES(SYNC_STAGES),
            .EDGE       (EDGE_MASK[g])
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .src    (irq_src_i[g]),
            .clr    (clr[g]),
            .pending(pending_o[g])
        );
    end

    assign cand = pending_o & irq_en_i;
    assign any  = |cand;

    always_comb begin
        win = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (cand[i]) win = ID_W'(i);
    end

    assign clr = (state == REQ && irq_ack_i) ? (NUM_SRC'(1) << id) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            id    <= '0;
        end else begin
            state <= state_nxt;
            id    <= id_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        id_nxt    = id;
        case (state)
            IDLE:    if (glb_en_i && any) begin
                         state_nxt = REQ;
                         id_nxt    = win;
                     end
            // id is frozen while requesting; ack takes precedence over withdrawal
            REQ:     if (irq_ack_i)                    state_nxt = SERVICE;
                     else if (!cand[id] || !glb_en_i)  state_nxt = IDLE;
            SERVICE: if (irq_done_i)                   state_nxt = IDLE;
            default:                                   state_nxt = IDLE;
        endcase
    end

    assign irq_req_o = (state == REQ);
    assign busy_o    = (state == SERVICE);
    assign irq_id_o  = id;
endmodule

// File: tb/tb_irq_controller.sv
// Scoreboarded bench for irq_controller: directed scenarios plus random traffic,
// checked every cycle against a sample-history reference model.

module tb_irq_controller;
    localparam int           N  = 8;
    localparam int           S  = 2;
    localparam logic [N-1:0] EM = 8'hFE;   // source 0 level, rest edge

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] src, en;
    logic         glb, ack, done;
    logic         req, busy;
    logic [2:0]   id;
    logic [N-1:0] pend;

    irq_controller #(
        .NUM_SRC(N), .ID_W(3), .EDGE_MASK(EM), .SYNC_STAGES(S)
    ) dut (
        .clk(clk), .rst(rst), .irq_src_i(src), .irq_en_i(en), .glb_en_i(glb),
        .irq_ack_i(ack), .irq_done_i(done), .irq_req_o(req), .irq_id_o(id),
        .pending_o(pend), .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         req;
        logic         busy;
        logic [2:0]   id;
        logic [N-1:0] pend;
    } obs_t;

    obs_t exp_q[$];
    int   grant_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // model state: samp[j] = source vector sampled j edges ago
    logic [N-1:0] samp [0:S+1];
    logic [N-1:0] m_pe;
    int           m_state;   // 0 idle, 1 requesting, 2 in service
    int           m_id;
    logic         req_d = 1'b0;
    logic [N-1:0] r_src;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int j = 0; j <= S + 1; j++) samp[j] = '0;
        m_pe    = '0;
        m_state = 0;
        m_id    = 0;
        exp_q.delete();
        grant_q.delete();
    endfunction

    task automatic model_edge();
        logic [N-1:0] pend_pre, cand, clr_v;
        int           win;
        obs_t         o;
        for (int j = S + 1; j > 0; j--) samp[j] = samp[j-1];
        samp[0]  = src;
        pend_pre = (m_pe & EM) | (samp[S] & ~EM);
        cand     = pend_pre & en;
        win      = -1;
        for (int i = 0; i < N; i++) if (cand[i] && win < 0) win = i;
        clr_v = '0;
        case (m_state)
            0: if (glb && win >= 0) begin
                   m_state = 1;
                   m_id    = win;
                   grant_q.push_back(win);
               end
            1: if (ack) begin
                   clr_v[m_id] = 1'b1;
                   m_state     = 2;
               end else if (!cand[m_id] || !glb) m_state = 0;
            default: if (done) m_state = 0;
        endcase
        m_pe   = (m_pe & ~clr_v) | (samp[S] & ~samp[S+1] & EM);
        o.req  = (m_state == 1);
        o.busy = (m_state == 2);
        o.id   = 3'(m_id);
        o.pend = (m_pe & EM) | (samp[S-1] & ~EM);
        exp_q.push_back(o);
    endtask

    task automatic monitor_cycle();
        obs_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("req",     32'(req),  32'(e.req));
            chk("busy",    32'(busy), 32'(e.busy));
            chk("id",      32'(id),   32'(e.id));
            chk("pending", 32'(pend), 32'(e.pend));
        end
        if (req && !req_d) begin
            chk("grant_avail", 32'(grant_q.size() != 0), 32'd1);
            if (grant_q.size() != 0) chk("grant_id", 32'(id), 32'(grant_q.pop_front()));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) monitor_cycle();
        req_d <= rst ? 1'b0 : req;
    end

    task automatic step(input logic [N-1:0] s, input logic [N-1:0] e,
                        input logic g, input logic a, input logic d);
        src = s; en = e; glb = g; ack = a; done = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic [N-1:0] s, input logic [N-1:0] e,
                       input logic g, input logic a, input logic d);
        for (int k = 0; k < n; k++) step(s, e, g, a, d);
    endtask

    initial begin
        rst = 1'b1; src = '0; en = '1; glb = 1'b1; ack = 1'b0; done = 1'b0;
        model_reset();
        #3;
        chk("rst_req",  32'(req),  32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_id",   32'(id),   32'd0);
        chk("rst_pend", 32'(pend), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // single pulse on source 3
        step(8'h08, '1, 1, 0, 0);
        run(2, 8'h00, '1, 1, 0, 0);
        chk("t1_pend", 32'(pend), 32'h08);
        chk("t1_req0", 32'(req),  32'd0);
        step(8'h00, '1, 1, 0, 0);
        chk("t1_req",  32'(req),  32'd1);
        chk("t1_id",   32'(id),   32'd3);
        step(8'h00, '1, 1, 1, 0);
        chk("t1_ack_pend", 32'(pend), 32'h00);
        chk("t1_busy",     32'(busy), 32'd1);
        step(8'h00, '1, 1, 0, 1);
        chk("t1_idle", 32'(busy), 32'd0);

        // simultaneous sources 5 and 2
        step(8'h24, '1, 1, 0, 0);
        run(3, 8'h00, '1, 1, 0, 0);
        chk("t2_id_first", 32'(id), 32'd2);
        step(8'h00, '1, 1, 1, 0);
        step(8'h00, '1, 1, 0, 1);
        step(8'h00, '1, 1, 0, 0);
        chk("t2_id_second", 32'(id),   32'd5);
        chk("t2_pend",      32'(pend), 32'h20);
        step(8'h00, '1, 1, 1, 0);
        step(8'h00, '1, 1, 0, 1);

        // masked source 1, then enabled
        step(8'h02, 8'hFD, 1, 0, 0);
        run(5, 8'h00, 8'hFD, 1, 0, 0);
        chk("t3_noreq", 32'(req),     32'd0);
        chk("t3_pend1", 32'(pend[1]), 32'd1);
        step(8'h00, '1, 1, 0, 0);
        chk("t3_req", 32'(req), 32'd1);
        chk("t3_id",  32'(id),  32'd1);
        step(8'h00, '1, 1, 1, 0);
        step(8'h00, '1, 1, 0, 1);

        // level source 0 withdrawn before ack
        run(3, 8'h01, '1, 1, 0, 0);
        chk("t4_req", 32'(req), 32'd1);
        run(2, 8'h00, '1, 1, 0, 0);
        chk("t4_req_hold", 32'(req), 32'd1);
        step(8'h00, '1, 1, 0, 0);
        chk("t4_withdraw", 32'(req),  32'd0);
        chk("t4_pend",     32'(pend), 32'd0);

        // re-trigger of source 4 while it is in service
        step(8'h10, '1, 1, 0, 0);
        run(3, 8'h00, '1, 1, 0, 0);
        step(8'h00, '1, 1, 1, 0);
        step(8'h10, '1, 1, 0, 0);
        run(3, 8'h00, '1, 1, 0, 0);
        chk("t5_pend4", 32'(pend[4]), 32'd1);
        chk("t5_busy",  32'(busy),    32'd1);
        step(8'h00, '1, 1, 0, 1);
        step(8'h00, '1, 1, 0, 0);
        chk("t5_rereq", 32'(id), 32'd4);
        step(8'h00, '1, 1, 1, 0);
        step(8'h00, '1, 1, 0, 1);

        // asynchronous reset mid-service, source 6 held high across it
        run(4, 8'h40, '1, 1, 0, 0);
        step(8'h40, '1, 1, 1, 0);
        chk("t6_busy_pre", 32'(busy), 32'd1);
        ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_req",  32'(req),  32'd0);
        chk("t6_rst_pend", 32'(pend), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        run(3, 8'h40, '1, 1, 0, 0);
        chk("t6_redetect", 32'(pend[6]), 32'd1);
        step(8'h40, '1, 1, 0, 0);
        step(8'h40, '1, 1, 1, 0);
        step(8'h00, '1, 1, 0, 1);

        // random traffic
        r_src = '0;
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) r_src[b] = ~r_src[b];
            step(r_src,
                 ($urandom_range(0, 9) == 0) ? N'($urandom) : '1,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0);
        end

        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
